// File: rtl/mem2nfifo.sv
// mem2nfifo: one shared write port feeding FLOWS independent show-ahead FIFO read ports.
// Optional MEM2NFIFO_ERR_EN adds sticky per-flow ERR (dropped write or READ without DATA_VLD).
module mem2nfifo #(
    parameter int DATA_WIDTH = 64,
    parameter int FLOWS      = 4,
    parameter int BLOCK_SIZE = 16,
    parameter int LUT_MEMORY = 0,
    localparam int AW = $clog2(FLOWS),
    localparam int PW = $clog2(BLOCK_SIZE),
    localparam int SW = PW + 1
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [DATA_WIDTH-1:0]       DATA_IN,
    input  logic [AW-1:0]               BLOCK_ADDR,
    input  logic                        WRITE,
    output logic [FLOWS-1:0]            FULL,
    output logic [FLOWS*DATA_WIDTH-1:0] DATA_OUT,
    output logic [FLOWS-1:0]            DATA_VLD,
    input  logic [FLOWS-1:0]            READ,
    output logic [FLOWS-1:0]            EMPTY,
    output logic [FLOWS*SW-1:0]         STATUS
`ifdef MEM2NFIFO_ERR_EN
    ,
    output logic [FLOWS-1:0]            ERR
`endif
);

    for (genvar i = 0; i < FLOWS; i++) begin : g_flow
        logic [PW-1:0]         wr_ptr, rd_ptr, wr_addr_q;
        logic [DATA_WIDTH-1:0] wr_data_q, mem_rd, dout;
        logic [SW-1:0]         count, count_nxt;
        logic                  wr_req, wr_acc, wr_q, ld, vld, vld_nxt, full, empty;

        // count includes the word still in the write stage; it is not readable until
        // the memory write lands, so the load only sees words already committed.
        always_comb begin
            wr_req    = WRITE && (BLOCK_ADDR == AW'(i));
            wr_acc    = wr_req && !full;
            ld        = (count > SW'(wr_q)) && (!vld || READ[i]);
            vld_nxt   = ld || (vld && !READ[i]);
            count_nxt = count + SW'(wr_acc) - SW'(ld);
        end

        if (LUT_MEMORY != 0) begin : g_lut
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [BLOCK_SIZE];
            always_ff @(posedge CLK) if (wr_q) mem[wr_addr_q] <= wr_data_q;
            assign mem_rd = mem[rd_ptr];
        end else begin : g_bram
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [BLOCK_SIZE];
            always_ff @(posedge CLK) if (wr_q) mem[wr_addr_q] <= wr_data_q;
            assign mem_rd = mem[rd_ptr];
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                wr_addr_q <= '0;
                wr_data_q <= '0;
                wr_q      <= 1'b0;
                count     <= '0;
                full      <= 1'b0;
                empty     <= 1'b1;
                vld       <= 1'b0;
                dout      <= '0;
            end else begin
                wr_q <= wr_acc;
                if (wr_acc) begin
                    wr_addr_q <= wr_ptr;
                    wr_data_q <= DATA_IN;
                    wr_ptr    <= wr_ptr + 1'b1;
                end
                if (ld) begin
                    dout   <= mem_rd;
                    rd_ptr <= rd_ptr + 1'b1;
                end
                vld   <= vld_nxt;
                count <= count_nxt;
                full  <= (count_nxt == SW'(BLOCK_SIZE));
                empty <= (count_nxt == '0) && !vld_nxt;
            end
        end

        assign FULL[i]                             = full;
        assign EMPTY[i]                            = empty;
        assign DATA_VLD[i]                         = vld;
        assign DATA_OUT[i*DATA_WIDTH +: DATA_WIDTH] = dout;
        assign STATUS[i*SW +: SW]                  = count;

`ifdef MEM2NFIFO_ERR_EN
        logic err;
        always_ff @(posedge CLK) begin
            if (RESET) err <= 1'b0;
            else       err <= err || (wr_req && full) || (READ[i] && !vld);
        end
        assign ERR[i] = err;
`endif
    end

endmodule

// File: tb/tb_mem2nfifo.sv
// Directed bench for mem2nfifo: vector table for single-word timing, then
// hand-written sequences for fill/drain, round-robin, wrap and mid-traffic reset.
module tb_mem2nfifo;
    localparam int DW = 64;
    localparam int F  = 4;
    localparam int SW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   din;
    logic [1:0]      addr;
    logic            wr;
    logic [F-1:0]    full, vld, rd, empty;
    logic [F*DW-1:0] dout;
    logic [F*SW-1:0] status;
`ifdef MEM2NFIFO_ERR_EN
    logic [F-1:0]    err;
`endif

    mem2nfifo #(.DATA_WIDTH(DW), .FLOWS(F), .BLOCK_SIZE(16), .LUT_MEMORY(0)) dut (
        .CLK(clk), .RESET(rst), .DATA_IN(din), .BLOCK_ADDR(addr), .WRITE(wr),
        .FULL(full), .DATA_OUT(dout), .DATA_VLD(vld), .READ(rd), .EMPTY(empty),
        .STATUS(status)
`ifdef MEM2NFIFO_ERR_EN
        , .ERR(err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] sb [F][$];
    int rcv [F];

    typedef struct {
        logic          rst;
        logic          wr;
        logic [1:0]    addr;
        logic [DW-1:0] din;
        logic [F-1:0]  rd;
        logic [F-1:0]  e_vld;
        logic [F-1:0]  e_empty;
        logic [F-1:0]  e_full;
        logic [F*SW-1:0] e_status;
        logic [1:0]    dflow;
        logic          chk_d;
        logic [DW-1:0] e_dout;
    } vec_t;
    vec_t tv [11];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Consumes every word the DUT presents while READ is high and checks FIFO order.
    task automatic monitor();
        for (int f = 0; f < F; f++) begin
            if (vld[f] && rd[f]) begin
                if (sb[f].size() == 0) chk($sformatf("unexpected_word_f%0d", f), dout[f*DW +: DW], '1);
                else chk($sformatf("order_f%0d", f), dout[f*DW +: DW], sb[f].pop_front());
                rcv[f]++;
            end
        end
    endtask

    task automatic cycle(input logic w, input logic [1:0] a, input logic [DW-1:0] d, input logic [F-1:0] r);
        wr = w; addr = a; din = d; rd = r;
        if (w && !full[a]) sb[a].push_back(d);
        monitor();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; rd = '0; din = '0; addr = '0;
        step();
        rst = 1'b0;
        for (int f = 0; f < F; f++) begin
            sb[f].delete();
            rcv[f] = 0;
        end
    endtask

    initial begin
        int written, smax, cyc;
        rst = 1'b1; wr = 1'b0; rd = '0; din = '0; addr = '0;

        tv[0]  = '{1'b1, 1'b0, 2'd0, 64'h0,  4'h0, 4'h0, 4'hF, 4'h0, 20'h00000, 2'd2, 1'b1, 64'h0};
        tv[1]  = '{1'b0, 1'b1, 2'd2, 64'hA5, 4'h0, 4'h0, 4'hB, 4'h0, 20'h00400, 2'd2, 1'b0, 64'h0};
        tv[2]  = '{1'b0, 1'b0, 2'd0, 64'h0,  4'h0, 4'h0, 4'hB, 4'h0, 20'h00400, 2'd2, 1'b0, 64'h0};
        tv[3]  = '{1'b0, 1'b0, 2'd0, 64'h0,  4'h0, 4'h4, 4'hB, 4'h0, 20'h00000, 2'd2, 1'b1, 64'hA5};
        tv[4]  = '{1'b0, 1'b0, 2'd0, 64'h0,  4'h4, 4'h0, 4'hF, 4'h0, 20'h00000, 2'd2, 1'b0, 64'h0};
        tv[5]  = '{1'b0, 1'b0, 2'd0, 64'h0,  4'h1, 4'h0, 4'hF, 4'h0, 20'h00000, 2'd0, 1'b0, 64'h0};
        tv[6]  = '{1'b0, 1'b1, 2'd1, 64'h11, 4'h0, 4'h0, 4'hD, 4'h0, 20'h00020, 2'd1, 1'b0, 64'h0};
        tv[7]  = '{1'b0, 1'b1, 2'd3, 64'h33, 4'h0, 4'h0, 4'h5, 4'h0, 20'h08020, 2'd3, 1'b0, 64'h0};
        tv[8]  = '{1'b0, 1'b0, 2'd0, 64'h0,  4'h0, 4'h2, 4'h5, 4'h0, 20'h08000, 2'd1, 1'b1, 64'h11};
        tv[9]  = '{1'b0, 1'b0, 2'd0, 64'h0,  4'h2, 4'h8, 4'h7, 4'h0, 20'h00000, 2'd3, 1'b1, 64'h33};
        tv[10] = '{1'b0, 1'b0, 2'd0, 64'h0,  4'h8, 4'h0, 4'hF, 4'h0, 20'h00000, 2'd3, 1'b0, 64'h0};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rst = tv[i].rst; wr = tv[i].wr; addr = tv[i].addr; din = tv[i].din; rd = tv[i].rd;
            step();
            chk($sformatf("v%0d_vld", i),    64'(vld),    64'(tv[i].e_vld));
            chk($sformatf("v%0d_empty", i),  64'(empty),  64'(tv[i].e_empty));
            chk($sformatf("v%0d_full", i),   64'(full),   64'(tv[i].e_full));
            chk($sformatf("v%0d_status", i), 64'(status), 64'(tv[i].e_status));
            if (tv[i].chk_d) chk($sformatf("v%0d_dout", i), dout[tv[i].dflow*DW +: DW], tv[i].e_dout);
        end

        // Fill flow 0: 16 words leave 15 in storage + 1 shown, 17th fills, 18th is dropped.
        do_reset();
        for (int k = 0; k < 16; k++) cycle(1'b1, 2'd0, 64'h100 + 64'(k), 4'h0);
        chk("fill16_status0", 64'(status[SW-1:0]), 64'd15);
        chk("fill16_full0",   64'(full[0]), 64'd0);
        chk("fill16_vld0",    64'(vld[0]), 64'd1);
        chk("fill16_dout0",   dout[DW-1:0], 64'h100);
        cycle(1'b1, 2'd0, 64'h110, 4'h0);
        chk("fill17_status0", 64'(status[SW-1:0]), 64'd16);
        chk("fill17_full0",   64'(full[0]), 64'd1);
        cycle(1'b1, 2'd0, 64'h111, 4'h0);
        chk("drop_status0",   64'(status[SW-1:0]), 64'd16);
        chk("drop_full0",     64'(full[0]), 64'd1);
`ifdef MEM2NFIFO_ERR_EN
        chk("drop_err", 64'(err), 64'h1);
`endif
        for (int i = 0; i < 20; i++) begin
            if (i < 17) chk($sformatf("drain_vld0_c%0d", i), 64'(vld[0]), 64'd1);
            cycle(1'b0, 2'd0, '0, 4'h1);
        end
        chk("drain_count0", 64'(rcv[0]), 64'd17);
        chk("drain_empty0", 64'(empty[0]), 64'd1);
        chk("drain_status0", 64'(status[SW-1:0]), 64'd0);

        // Round-robin 0..63 with every flow draining.
        do_reset();
        for (int k = 0; k < 64; k++) cycle(1'b1, 2'(k % 4), 64'(k), 4'hF);
        for (int k = 0; k < 6; k++) cycle(1'b0, 2'd0, '0, 4'hF);
        for (int f = 0; f < F; f++) chk($sformatf("rr_count_f%0d", f), 64'(rcv[f]), 64'd16);
        chk("rr_empty", 64'(empty), 64'hF);

        // Flow 3 with READ toggling: exercises full back-pressure and pointer wrap.
        do_reset();
        written = 0; smax = 0; cyc = 0;
        while (rcv[3] < 40 && cyc < 2000) begin
            logic w;
            w = (written < 40) && !full[3];
            cycle(w, 2'd3, 64'h300 + 64'(written), {cyc[0], 3'b000});
            if (w) written++;
            if (int'(status[3*SW +: SW]) > smax) smax = int'(status[3*SW +: SW]);
            cyc++;
        end
        chk("wrap_count3", 64'(rcv[3]), 64'd40);
        chk("wrap_status_max", 64'(smax), 64'd16);
        chk("wrap_empty3", 64'(empty[3]), 64'd1);

        // Reset while every flow holds 5 words discards everything.
        do_reset();
        for (int k = 0; k < 20; k++) cycle(1'b1, 2'(k % 4), 64'h400 + 64'(k), 4'h0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, '0, 4'h0);
        chk("pre_rst_status", 64'(status), 64'({5'd4, 5'd4, 5'd4, 5'd4}));
        chk("pre_rst_vld", 64'(vld), 64'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_vld",    64'(vld), 64'h0);
        chk("rst_empty",  64'(empty), 64'hF);
        chk("rst_status", 64'(status), 64'h0);
        chk("rst_full",   64'(full), 64'h0);
        chk("rst_dout0",  dout[DW-1:0], 64'h0);
        chk("rst_dout3",  dout[3*DW +: DW], 64'h0);
`ifdef MEM2NFIFO_ERR_EN
        chk("rst_err", 64'(err), 64'h0);
`endif
        for (int f = 0; f < F; f++) sb[f].delete();
        for (int k = 0; k < 3; k++) step();
        chk("post_rst_vld", 64'(vld), 64'h0);
        chk("post_rst_status", 64'(status), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
